// File: rtl/fsm_seq_gen.sv
// Serial pattern transmitter: accepts a DATA_W-bit frame on valid/ready and shifts it
// out MSB-first, optionally repeating it with a fixed idle gap between repeats.
module fsm_seq_gen #(
  parameter int DATA_W  = 8,
  parameter int GAP_LEN = 2
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [DATA_W-1:0] i_data,
  input  logic [3:0]        i_rpt,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_seq,
  output logic              o_seq_valid,
  output logic              o_busy,
  output logic              o_done
);
  localparam int BW = $clog2(DATA_W);
  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  // GAP_LEN=0 never enters S_GAP, so the reload value is irrelevant there
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic [DATA_W-1:0] frame, frame_nx;
  logic [BW-1:0]     bitcnt, bitcnt_nx;
  logic [3:0]        rptcnt, rptcnt_nx;
  logic [GW-1:0]     gapcnt, gapcnt_nx;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state  <= S_IDLE;
      shreg  <= '0;
      frame  <= '0;
      bitcnt <= '0;
      rptcnt <= '0;
      gapcnt <= '0;
    end else begin
      state  <= state_nx;
      shreg  <= shreg_nx;
      frame  <= frame_nx;
      bitcnt <= bitcnt_nx;
      rptcnt <= rptcnt_nx;
      gapcnt <= gapcnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    frame_nx  = frame;
    bitcnt_nx = bitcnt;
    rptcnt_nx = rptcnt;
    gapcnt_nx = gapcnt;
    case (state)
      S_IDLE: begin
        if (i_valid) begin
          shreg_nx  = i_data;
          frame_nx  = i_data;
          rptcnt_nx = i_rpt;
          bitcnt_nx = BIT_LAST;
          state_nx  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bitcnt != '0) begin
          shreg_nx  = {shreg[DATA_W-2:0], 1'b0};
          bitcnt_nx = bitcnt - 1'b1;
        end else if (rptcnt == '0) begin
          state_nx = S_DONE;
        end else begin
          // reload the saved frame for the next repeat
          rptcnt_nx = rptcnt - 1'b1;
          shreg_nx  = frame;
          bitcnt_nx = BIT_LAST;
          if (GAP_LEN != 0) begin
            gapcnt_nx = GAP_LAST;
            state_nx  = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gapcnt == '0) state_nx = S_SHIFT;
        else              gapcnt_nx = gapcnt - 1'b1;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Moore outputs: decoded from registered state only
  always_comb begin
    o_ready     = 1'b0;
    o_seq       = 1'b0;
    o_seq_valid = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (state)
      S_IDLE: begin
        o_ready = 1'b1;
        o_busy  = 1'b0;
      end
      S_SHIFT: begin
        o_seq       = shreg[DATA_W-1];
        o_seq_valid = 1'b1;
      end
      S_GAP:   ;
      S_DONE:  o_done = 1'b1;
      default: begin
        o_ready = 1'b1;
        o_busy  = 1'b0;
      end
    endcase
  end

endmodule
